// File: rtl/fft_out_serializer_if.sv
// fft_out_serializer_if: sample type plus frame-in / bin-out stream bundle for fft_out_serializer
package fft_out_serializer_pkg;
  typedef struct packed {
    logic signed [31:0] r;
    logic signed [31:0] i;
  } complex_product_t;
endpackage

interface fft_out_serializer_if #(parameter int N = 32);
  import fft_out_serializer_pkg::*;
  localparam int IDX_W = $clog2(N);
  complex_product_t [N-1:0] in_frame;
  logic in_mode;
  logic in_valid;
  complex_product_t out_data;
  logic [IDX_W-1:0] out_index;
  logic out_mode;
  logic out_valid;
  logic out_last;
  logic out_ready;
  modport master (
    output in_frame, in_mode, in_valid, out_ready,
    input  out_data, out_index, out_mode, out_valid, out_last
  );
  modport slave (
    input  in_frame, in_mode, in_valid, out_ready,
    output out_data, out_index, out_mode, out_valid, out_last
  );
endinterface

// File: rtl/fft_out_serializer.sv
// fft_out_serializer: ping-pong frame buffer streaming FFT bins one per cycle; FFT_OUT_BITREV_EN selects bit-reversed readout
module fft_out_serializer
  import fft_out_serializer_pkg::*;
#(
  parameter int N = 32,
  parameter int IDX_W = $clog2(N)
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  fft_out_serializer_if.slave bus,
  output logic overflow,
  output logic [15:0] drop_count
);
  typedef enum logic {IDLE, STREAM} st_t;
  st_t st_q, st_d;
  complex_product_t [N-1:0] mem_q [2];
  logic [1:0] mode_q;
  logic [1:0] full_q, full_d;
  logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0] bin_q, bin_d, idx;
  logic overflow_q, overflow_d;
  logic [15:0] drop_q, drop_d;
  logic vld, hs, last_hs, cap, drop;
`ifdef FFT_OUT_BITREV_EN
  assign idx = {<<{bin_q}};
`else
  assign idx = bin_q;
`endif
  always_comb begin
    vld = st_q == STREAM;
    hs = vld && bus.out_ready;
    last_hs = hs && bin_q == IDX_W'(N - 1);
    // a buffer finishing its final beat this edge can be refilled at the same edge
    cap = enable && bus.in_valid && (!full_q[wr_sel_q] || (last_hs && rd_sel_q == wr_sel_q));
    drop = enable && bus.in_valid && !cap;
    full_d = (full_q & ~(2'(last_hs) << rd_sel_q)) | (2'(cap) << wr_sel_q);
    rd_sel_d = rd_sel_q ^ last_hs;
    wr_sel_d = wr_sel_q ^ cap;
    st_d = full_d[rd_sel_d] ? STREAM : IDLE;
    bin_d = (hs && !last_hs) ? bin_q + 1'b1 : (vld && !hs) ? bin_q : '0;
    overflow_d = overflow_q | drop;
    drop_d = drop_q + 16'(drop && drop_q != 16'hFFFF);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      full_q <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      bin_q <= '0;
      overflow_q <= 1'b0;
      drop_q <= '0;
    end else begin
      st_q <= st_d;
      full_q <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      bin_q <= bin_d;
      overflow_q <= overflow_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (cap) begin
      mem_q[wr_sel_q] <= bus.in_frame;
      mode_q[wr_sel_q] <= bus.in_mode;
    end
  end
  assign bus.out_valid = vld;
  assign bus.out_data = vld ? mem_q[rd_sel_q][idx] : '0;
  assign bus.out_index = idx;
  assign bus.out_mode = vld && mode_q[rd_sel_q];
  assign bus.out_last = vld && bin_q == IDX_W'(N - 1);
  assign overflow = overflow_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_fft_out_serializer.sv
// tb_fft_out_serializer: directed checks of capture, streaming, back-pressure, drops and reset with N=8
module tb_fft_out_serializer;
  import fft_out_serializer_pkg::*;
  logic clk = 1'b0;
  logic reset, enable, overflow;
  logic [15:0] drop_count;
  int errors = 0;
  int checks = 0;
  int rev [8];
  fft_out_serializer_if #(.N(8)) bus ();
  fft_out_serializer #(.N(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus),
    .overflow(overflow), .drop_count(drop_count)
  );
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(int f, bit m);
    for (int j = 0; j < 8; j++) begin
      bus.in_frame[j].r = 16 * f + j;
      bus.in_frame[j].i = -(16 * f + j);
    end
    bus.in_mode = m;
  endtask

  task automatic beat(int f, int j, bit m);
    int k;
    logic [31:0] v;
    k = rev[j];
    v = 32'(16 * f + k);
    chk($sformatf("valid f%0d b%0d", f, j), 64'(bus.out_valid), 64'd1);
    chk($sformatf("data f%0d b%0d", f, j), 64'(bus.out_data), {v, -v});
    chk($sformatf("index f%0d b%0d", f, j), 64'(bus.out_index), 64'(k));
    chk($sformatf("mode f%0d b%0d", f, j), 64'(bus.out_mode), 64'(m));
    chk($sformatf("last f%0d b%0d", f, j), 64'(bus.out_last), 64'(j == 7));
  endtask

  task automatic idle(string tag);
    chk({tag, " valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " last"}, 64'(bus.out_last), 64'd0);
  endtask

  initial begin
`ifdef FFT_OUT_BITREV_EN
    rev = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    rev = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    reset = 1'b1;
    enable = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    load(0, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    idle("reset");
    chk("reset index", 64'(bus.out_index), 64'd0);
    chk("reset mode", 64'(bus.out_mode), 64'd0);
    chk("reset data", 64'(bus.out_data), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    chk("reset drops", 64'(drop_count), 64'd0);

    // single frame, first beat right after the capture edge
    load(0, 1'b1);
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      beat(0, j, 1'b1);
      cyc();
    end
    idle("single end");

    // two back-to-back frames, no bubble
    load(0, 1'b0);
    bus.in_valid = 1'b1;
    cyc();
    beat(0, 0, 1'b0);
    load(1, 1'b1);
    cyc();
    bus.in_valid = 1'b0;
    for (int b = 1; b < 16; b++) begin
      beat(b / 8, b % 8, b >= 8);
      cyc();
    end
    idle("pair end");
    chk("pair overflow", 64'(overflow), 64'd0);

    // third frame dropped while two are held
    bus.out_ready = 1'b0;
    load(0, 1'b0);
    bus.in_valid = 1'b1;
    cyc();
    load(1, 1'b1);
    cyc();
    load(2, 1'b0);
    cyc();
    bus.in_valid = 1'b0;
    chk("drop overflow", 64'(overflow), 64'd1);
    chk("drop count", 64'(drop_count), 64'd1);
    beat(0, 0, 1'b0);
    cyc();
    cyc();
    beat(0, 0, 1'b0);
    bus.out_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      beat(b / 8, b % 8, b >= 8);
      cyc();
    end
    idle("drop end");
    chk("drop count stable", 64'(drop_count), 64'd1);

    // alternating ready: each bin held through its ready-low cycle
    load(3, 1'b1);
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      beat(3, (c + 1) / 2, 1'b1);
      bus.out_ready = (c % 2 == 0);
      cyc();
    end
    idle("bp end");
    bus.out_ready = 1'b1;

    // refill of the draining buffer on its final handshake
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst2 overflow", 64'(overflow), 64'd0);
    chk("rst2 drops", 64'(drop_count), 64'd0);
    bus.out_ready = 1'b0;
    load(0, 1'b0);
    bus.in_valid = 1'b1;
    cyc();
    load(1, 1'b1);
    cyc();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 7; j++) begin
      beat(0, j, 1'b0);
      cyc();
    end
    beat(0, 7, 1'b0);
    load(2, 1'b0);
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    chk("edge overflow", 64'(overflow), 64'd0);
    chk("edge drops", 64'(drop_count), 64'd0);
    for (int b = 0; b < 16; b++) begin
      beat(1 + b / 8, b % 8, b < 8);
      cyc();
    end
    idle("edge end");

    // disabled capture is neither stored nor counted
    enable = 1'b0;
    load(4, 1'b1);
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    idle("disabled");
    cyc();
    idle("disabled later");
    chk("disabled drops", 64'(drop_count), 64'd0);
    chk("disabled overflow", 64'(overflow), 64'd0);
    enable = 1'b1;

    // reset mid-frame, with a frame offered during the reset cycle
    load(5, 1'b1);
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    beat(5, 0, 1'b1);
    cyc();
    cyc();
    beat(5, 2, 1'b1);
    reset = 1'b1;
    load(6, 1'b1);
    bus.in_valid = 1'b1;
    cyc();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    idle("midrst");
    chk("midrst data", 64'(bus.out_data), 64'd0);
    chk("midrst index", 64'(bus.out_index), 64'd0);
    chk("midrst mode", 64'(bus.out_mode), 64'd0);
    chk("midrst drops", 64'(drop_count), 64'd0);
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk($sformatf("midrst quiet %0d", c), 64'(bus.out_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
